// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC playback path.
package dac_pkg;

    localparam int unsigned SAMPLES_PER_WORD = 8;
    localparam int unsigned SAMPLE_W         = 16;
    localparam int unsigned WORD_W           = SAMPLES_PER_WORD * SAMPLE_W;
    localparam int unsigned IDX_W            = $clog2(SAMPLES_PER_WORD);

    localparam logic [SAMPLE_W-1:0] IDLE_CODE_DEFAULT = 16'h8000;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [WORD_W-1:0]   word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Oldest sample sits in the top slice of a word.
    function automatic sample_t first_sample(input word_t w);
        return w[WORD_W-1 -: SAMPLE_W];
    endfunction

endpackage

// File: rtl/word_fifo_sync.sv
// Single-clock word FIFO with registered level/full/empty and a one-clock flush.
module word_fifo_sync #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_d;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign rd_data_c = mem[rd_ptr_q];

    always_comb begin
        level_d = level;
        if (flush) begin
            level_d = '0;
        end else if (do_push && !do_pop) begin
            level_d = level + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_d = level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level <= level_d;
            full  <= (level_d == LVL_W'(DEPTH));
            empty <= (level_d == '0);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/dac_word_unpacker.sv
// Buffers 128-bit sample words and plays one 16-bit sample per rate slot to the DAC.
module dac_word_unpacker
    import dac_pkg::*;
#(
    parameter int unsigned   FIFO_DEPTH  = 4,
    parameter int unsigned   PRIME_WORDS = 2,
    parameter logic [15:0]   IDLE_CODE   = IDLE_CODE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [127:0]                  word_data,
    input  logic                          word_valid,
    output logic                          word_ready,
    input  logic                          play_en,
    input  logic [7:0]                    rate_div,
    output logic [15:0]                   dac_data,
    output logic                          dac_data_vld,
    output logic                          underflow,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       rate_q, rate_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    word_t            shreg_q, shreg_d;
    logic             need_word_q, need_word_d;
    sample_t          dac_d;
    logic             vld_d;
    logic             underflow_d;

    logic             fifo_pop_c;
    logic             fifo_flush_c;
    word_t            fifo_head_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic             slot_c;

    word_fifo_sync #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (word_valid),
        .pop       (fifo_pop_c),
        .flush     (fifo_flush_c),
        .wr_data   (word_data),
        .rd_data_c (fifo_head_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign word_ready = !fifo_full;
    assign slot_c     = (state_q != IDLE) && (cnt_q == rate_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rate_d       = rate_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        need_word_d  = need_word_q;
        dac_d        = dac_data;
        vld_d        = 1'b0;
        underflow_d  = underflow;
        fifo_pop_c   = 1'b0;
        fifo_flush_c = 1'b0;

        // rate_div is only taken on slot boundaries so a slot never stretches mid-count
        if (state_q == IDLE || slot_c) begin
            cnt_d  = '0;
            rate_d = rate_div;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                dac_d = IDLE_CODE;
                if (play_en) begin
                    state_d     = PRIME;
                    underflow_d = 1'b0;
                end
            end
            PRIME: begin
                if (!play_en) begin
                    state_d = IDLE;
                end else if (fifo_level >= LVL_W'(PRIME_WORDS)) begin
                    state_d     = PLAY;
                    shreg_d     = fifo_head_c;
                    fifo_pop_c  = 1'b1;
                    idx_d       = '0;
                    need_word_d = 1'b0;
                    cnt_d       = '0;
                    rate_d      = rate_div;
                end
            end
            PLAY: begin
                if (!play_en) state_d = DRAIN;
            end
            DRAIN: begin
                if (play_en) begin
                    state_d = PLAY;
                end else if (need_word_q) begin
                    fifo_flush_c = 1'b1;
                    dac_d        = IDLE_CODE;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // New words are only fetched while playback is still requested.
        if (slot_c && (state_q == PLAY || state_q == DRAIN)) begin
            if (!need_word_q) begin
                dac_d = first_sample(shreg_q);
                vld_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (play_en && !fifo_empty) begin
                        shreg_d    = fifo_head_c;
                        fifo_pop_c = 1'b1;
                    end else begin
                        need_word_d = 1'b1;
                    end
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    shreg_d = shreg_q << SAMPLE_W;
                end
            end else if (play_en && !fifo_empty) begin
                dac_d       = first_sample(fifo_head_c);
                vld_d       = 1'b1;
                shreg_d     = fifo_head_c << SAMPLE_W;
                idx_d       = IDX_W'(1);
                fifo_pop_c  = 1'b1;
                need_word_d = 1'b0;
            end else if (state_q == PLAY) begin
                dac_d       = IDLE_CODE;
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rate_q       <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            need_word_q  <= 1'b1;
            dac_data     <= IDLE_CODE;
            dac_data_vld <= 1'b0;
            underflow    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rate_q       <= rate_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            need_word_q  <= need_word_d;
            dac_data     <= dac_d;
            dac_data_vld <= vld_d;
            underflow    <= underflow_d;
            busy         <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_dac_word_unpacker.sv
// Directed self-checking bench for dac_word_unpacker.
module tb_dac_word_unpacker;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] word_data;
    logic         word_valid;
    logic         word_ready;
    logic         play_en;
    logic [7:0]   rate_div;
    logic [15:0]  dac_data;
    logic         dac_data_vld;
    logic         underflow;
    logic         busy;
    logic [2:0]   fifo_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] samp_q[$];
    int          stamp_q[$];
    logic        und_q[$];

    dac_word_unpacker #(
        .FIFO_DEPTH  (4),
        .PRIME_WORDS (1),
        .IDLE_CODE   (16'h8000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .play_en      (play_en),
        .rate_div     (rate_div),
        .dac_data     (dac_data),
        .dac_data_vld (dac_data_vld),
        .underflow    (underflow),
        .busy         (busy),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every emitted sample with its cycle stamp and the underflow flag.
    always begin
        @(posedge clk);
        #1;
        if (dac_data_vld) begin
            samp_q.push_back(dac_data);
            stamp_q.push_back(cyc);
            und_q.push_back(underflow);
        end
    end

    function automatic logic [127:0] mk_word(input logic [15:0] base);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[127 - 16*i -: 16] = base + 16'(i);
        return w;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [127:0] w);
        word_data  = w;
        word_valid = 1'b1;
        step(1);
        word_valid = 1'b0;
    endtask

    task automatic clear_log();
        samp_q.delete();
        stamp_q.delete();
        und_q.delete();
    endtask

    task automatic do_reset();
        play_en    = 1'b0;
        word_valid = 1'b0;
        rst_n      = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        clear_log();
    endtask

    task automatic wait_samples(input int n, input int bound);
        int k = 0;
        while (samp_q.size() < n && k < bound) begin
            step(1);
            k++;
        end
    endtask

    task automatic test_reset();
        play_en    = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        rate_div   = 8'd0;
        rst_n      = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dac_data !== 16'h8000) begin failures++; $display("FAIL reset_dac got=%h exp=8000", dac_data); end
        checks++; if (dac_data_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", dac_data_vld); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (word_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", word_ready); end
        step(2);
        rst_n = 1'b1;
        step(1);
        clear_log();
    endtask

    task automatic test_idle_push();
        push_word(mk_word(16'h0001));
        step(10);
        checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL idle_level got=%0d exp=1", fifo_level); end
        checks++; if (dac_data !== 16'h8000) begin failures++; $display("FAIL idle_dac got=%h exp=8000", dac_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
        checks++; if (samp_q.size() != 0) begin failures++; $display("FAIL idle_vld_pulses got=%0d exp=0", samp_q.size()); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        rate_div = 8'd0;
        push_word(mk_word(16'h0001));
        push_word(mk_word(16'h0009));
        play_en = 1'b1;
        wait_samples(16, 40);
        checks++; if (samp_q.size() < 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", samp_q.size()); end
        for (int i = 0; i < 16 && i < samp_q.size(); i++) begin
            checks++;
            if (samp_q[i] !== 16'(i + 1)) begin failures++; $display("FAIL b2b_value idx=%0d got=%h exp=%h", i, samp_q[i], 16'(i + 1)); end
            if (i > 0) begin
                checks++;
                if (stamp_q[i] - stamp_q[i-1] != 1) begin failures++; $display("FAIL b2b_gap idx=%0d got=%0d exp=1", i, stamp_q[i] - stamp_q[i-1]); end
            end
        end
        if (samp_q.size() >= 16) begin
            checks++; if (und_q[15] !== 1'b0) begin failures++; $display("FAIL b2b_underflow got=%b exp=0", und_q[15]); end
        end
        do_reset();
    endtask

    task automatic test_underflow();
        int k;
        rate_div = 8'd3;
        push_word(mk_word(16'h0100));
        play_en = 1'b1;
        wait_samples(8, 60);
        checks++; if (samp_q.size() != 8) begin failures++; $display("FAIL uf_count got=%0d exp=8", samp_q.size()); end
        for (int i = 0; i < 8 && i < samp_q.size(); i++) begin
            checks++;
            if (samp_q[i] !== 16'h0100 + 16'(i)) begin failures++; $display("FAIL uf_value idx=%0d got=%h exp=%h", i, samp_q[i], 16'h0100 + 16'(i)); end
            if (i > 0) begin
                checks++;
                if (stamp_q[i] - stamp_q[i-1] != 4) begin failures++; $display("FAIL uf_spacing idx=%0d got=%0d exp=4", i, stamp_q[i] - stamp_q[i-1]); end
            end
        end
        k = 0;
        while (underflow !== 1'b1 && k < 20) begin step(1); k++; end
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_flag got=%b exp=1", underflow); end
        checks++; if (dac_data !== 16'h8000) begin failures++; $display("FAIL uf_dac got=%h exp=8000", dac_data); end
        checks++; if (samp_q.size() != 8) begin failures++; $display("FAIL uf_no_extra got=%0d exp=8", samp_q.size()); end
        push_word(mk_word(16'h0200));
        wait_samples(9, 20);
        checks++; if (samp_q.size() < 9) begin failures++; $display("FAIL uf_resume_count got=%0d exp=9", samp_q.size()); end
        if (samp_q.size() >= 9) begin
            checks++; if (samp_q[8] !== 16'h0200) begin failures++; $display("FAIL uf_resume_value got=%h exp=0200", samp_q[8]); end
            checks++; if ((stamp_q[8] - stamp_q[7]) % 4 != 0) begin failures++; $display("FAIL uf_resume_slot got=%0d exp=multiple_of_4", stamp_q[8] - stamp_q[7]); end
        end
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", underflow); end
        do_reset();
    endtask

    task automatic test_fifo_full();
        push_word(mk_word(16'h0A00));
        push_word(mk_word(16'h0B00));
        push_word(mk_word(16'h0C00));
        checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL full_level3 got=%0d exp=3", fifo_level); end
        checks++; if (word_ready !== 1'b1) begin failures++; $display("FAIL full_ready3 got=%b exp=1", word_ready); end
        push_word(mk_word(16'h0D00));
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_level4 got=%0d exp=4", fifo_level); end
        checks++; if (word_ready !== 1'b0) begin failures++; $display("FAIL full_ready4 got=%b exp=0", word_ready); end
        push_word(mk_word(16'h0E00));
        step(1);
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_drop_level got=%0d exp=4", fifo_level); end
        checks++; if (word_ready !== 1'b0) begin failures++; $display("FAIL full_drop_ready got=%b exp=0", word_ready); end
        rate_div = 8'd0;
        play_en  = 1'b1;
        wait_samples(32, 80);
        step(10);
        checks++; if (samp_q.size() != 32) begin failures++; $display("FAIL full_total got=%0d exp=32", samp_q.size()); end
        if (samp_q.size() >= 32) begin
            checks++; if (samp_q[24] !== 16'h0D00) begin failures++; $display("FAIL full_word4 got=%h exp=0d00", samp_q[24]); end
            checks++; if (samp_q[31] !== 16'h0D07) begin failures++; $display("FAIL full_last got=%h exp=0d07", samp_q[31]); end
        end
        do_reset();
    endtask

    task automatic test_drain();
        int k;
        rate_div = 8'd1;
        push_word(mk_word(16'h1000));
        push_word(mk_word(16'h2000));
        push_word(mk_word(16'h3000));
        play_en = 1'b1;
        wait_samples(3, 40);
        play_en = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 60) begin step(1); k++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_idle got=%b exp=0", busy); end
        checks++; if (samp_q.size() != 8) begin failures++; $display("FAIL drain_count got=%0d exp=8", samp_q.size()); end
        for (int i = 0; i < 8 && i < samp_q.size(); i++) begin
            checks++;
            if (samp_q[i] !== 16'h1000 + 16'(i)) begin failures++; $display("FAIL drain_value idx=%0d got=%h exp=%h", i, samp_q[i], 16'h1000 + 16'(i)); end
        end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", fifo_level); end
        checks++; if (dac_data !== 16'h8000) begin failures++; $display("FAIL drain_dac got=%h exp=8000", dac_data); end
        step(10);
        checks++; if (samp_q.size() != 8) begin failures++; $display("FAIL drain_quiet got=%0d exp=8", samp_q.size()); end
        do_reset();
    endtask

    task automatic test_reset_mid_play();
        rate_div = 8'd2;
        push_word(mk_word(16'h4000));
        push_word(mk_word(16'h5000));
        push_word(mk_word(16'h6000));
        play_en = 1'b1;
        wait_samples(2, 40);
        checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL mid_level got=%0d exp=2", fifo_level); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (dac_data !== 16'h8000) begin failures++; $display("FAIL mid_rst_dac got=%h exp=8000", dac_data); end
        checks++; if (dac_data_vld !== 1'b0) begin failures++; $display("FAIL mid_rst_vld got=%b exp=0", dac_data_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL mid_rst_level got=%0d exp=0", fifo_level); end
        checks++; if (word_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", word_ready); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL mid_rst_underflow got=%b exp=0", underflow); end
        play_en = 1'b0;
        step(2);
        rst_n = 1'b1;
        clear_log();
        step(20);
        checks++; if (samp_q.size() != 0) begin failures++; $display("FAIL mid_stale_idle got=%0d exp=0", samp_q.size()); end
        play_en = 1'b1;
        step(10);
        checks++; if (samp_q.size() != 0) begin failures++; $display("FAIL mid_stale_prime got=%0d exp=0", samp_q.size()); end
        checks++; if (dac_data !== 16'h8000) begin failures++; $display("FAIL mid_stale_dac got=%h exp=8000", dac_data); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_idle_push();
        test_back_to_back();
        test_underflow();
        test_fifo_full();
        test_drain();
        test_reset_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
